// File: rtl/err_detect_responder.sv
// Timing-error detector answering the controller's sample handshake on dual-rail err0/err1.
// Optional inject port for forced errors is enabled by defining ERR_INJECT_EN.
module err_detect_responder #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              latch,
    input  logic              sample,
`ifdef ERR_INJECT_EN
    input  logic              inject,
`endif
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] q_out,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              proto_err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CAPT = 3'd1,
        EVAL = 3'd2,
        RESP = 3'd3,
        RTZ  = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [SYNC_STAGES-1:0]   latch_sync_q, sample_sync_q;
    logic                     latch_dly_q, sample_dly_q;
    logic [DATA_W-1:0]        q_q, q_d, shadow_q, shadow_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     err0_q, err0_d, err1_q, err1_d;
    logic                     proto_q, proto_d, force_q, force_d;
    logic                     latch_s, sample_s, latch_rise_s, sample_rise_s, sample_fall_s;
    logic                     inject_s, mismatch_s;

`ifdef ERR_INJECT_EN
    assign inject_s = inject;
`else
    assign inject_s = 1'b0;
`endif

    assign latch_s       = latch_sync_q[SYNC_STAGES-1];
    assign sample_s      = sample_sync_q[SYNC_STAGES-1];
    assign latch_rise_s  = latch_s & ~latch_dly_q;
    assign sample_rise_s = sample_s & ~sample_dly_q;
    assign sample_fall_s = ~sample_s & sample_dly_q;
    assign mismatch_s    = (shadow_q != q_q) | force_q | inject_s;

    // Input synchronizers and previous-cycle copies for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            latch_sync_q  <= {SYNC_STAGES{1'b0}};
            sample_sync_q <= {SYNC_STAGES{1'b0}};
            latch_dly_q   <= 1'b0;
            sample_dly_q  <= 1'b0;
        end else begin
            latch_sync_q  <= {latch_sync_q[SYNC_STAGES-2:0], latch};
            sample_sync_q <= {sample_sync_q[SYNC_STAGES-2:0], sample};
            latch_dly_q   <= latch_s;
            sample_dly_q  <= sample_s;
        end
    end

    // State, datapath and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            q_q      <= {DATA_W{1'b0}};
            shadow_q <= {DATA_W{1'b0}};
            cnt_q    <= {CNT_W{1'b0}};
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
            proto_q  <= 1'b0;
            force_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            q_q      <= q_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            err0_q   <= err0_d;
            err1_q   <= err1_d;
            proto_q  <= proto_d;
            force_q  <= force_d;
        end
    end

    // Handshake FSM next-state and register updates
    always_comb begin
        state_d  = state_q;
        q_d      = q_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        err0_d   = err0_q;
        err1_d   = err1_q;
        proto_d  = proto_q;
        force_d  = force_q;
        case (state_q)
            IDLE: begin
                if (latch_rise_s) begin
                    q_d = data_in;
                    if (sample_rise_s) begin
                        shadow_d = data_in;
                        force_d  = 1'b0;
                        state_d  = EVAL;
                    end else begin
                        state_d  = CAPT;
                    end
                end else if (sample_rise_s) begin
                    // sample with nothing captured: protocol violation, always answered as an error
                    shadow_d = data_in;
                    proto_d  = 1'b1;
                    force_d  = 1'b1;
                    state_d  = EVAL;
                end else begin
                    state_d  = IDLE;
                end
            end
            CAPT: begin
                if (latch_rise_s) begin
                    q_d = data_in;
                end else begin
                    q_d = q_q;
                end
                if (sample_rise_s) begin
                    shadow_d = data_in;
                    force_d  = 1'b0;
                    state_d  = EVAL;
                end else begin
                    state_d  = CAPT;
                end
            end
            EVAL: begin
                force_d = 1'b0;
                if (!sample_s) begin
                    state_d = IDLE;
                end else if (mismatch_s) begin
                    err1_d  = 1'b1;
                    q_d     = shadow_q;
                    cnt_d   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    state_d = RESP;
                end else begin
                    err0_d  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (sample_fall_s) begin
                    err0_d  = 1'b0;
                    err1_d  = 1'b0;
                    state_d = RTZ;
                end else begin
                    state_d = RESP;
                end
            end
            RTZ: begin
                if (latch_rise_s) begin
                    q_d     = data_in;
                    state_d = CAPT;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                err0_d  = 1'b0;
                err1_d  = 1'b0;
                force_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    assign err0      = err0_q;
    assign err1      = err1_q;
    assign q_out     = q_q;
    assign err_cnt   = cnt_q;
    assign proto_err = proto_q;

endmodule

// File: tb/tb_err_detect_responder.sv
// Directed and randomized handshake bench for err_detect_responder, checked against a
// transaction-level model of capture/compare/correct/count behaviour.
module tb_err_detect_responder;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
`ifdef ERR_INJECT_EN
    localparam bit INJ_BUILD = 1'b1;
`else
    localparam bit INJ_BUILD = 1'b0;
`endif

    logic              clk, rst, latch, sample, inject;
    logic [DATA_W-1:0] data_in, q_out;
    logic              err0, err1, proto_err;
    logic [CNT_W-1:0]  err_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // Transaction-level reference state
    logic [DATA_W-1:0] m_q;
    int                m_cnt;
    bit                m_proto, m_captured;

    err_detect_responder #(.DATA_W(DATA_W), .SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .latch     (latch),
        .sample    (sample),
`ifdef ERR_INJECT_EN
        .inject    (inject),
`endif
        .err0      (err0),
        .err1      (err1),
        .q_out     (q_out),
        .err_cnt   (err_cnt),
        .proto_err (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q = '0; m_cnt = 0; m_proto = 1'b0; m_captured = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".q_out"}, 32'(q_out), 32'(m_q));
        check({tag, ".err_cnt"}, 32'(err_cnt), 32'(m_cnt));
        check({tag, ".proto_err"}, 32'(proto_err), 32'(m_proto));
    endtask

    task automatic do_latch(input logic [DATA_W-1:0] d);
        @(negedge clk);
        data_in = d;
        latch   = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        latch = 1'b0;
        repeat (4) @(posedge clk);
        m_q = d;
        m_captured = 1'b1;
        #1 check("latch.q_out", 32'(q_out), 32'(m_q));
    endtask

    // Full 4-phase sample handshake with latency checks on assert and release
    task automatic do_sample(input string tag, input logic [DATA_W-1:0] d,
                             input bit with_latch, input bit inj);
        bit exp_err;
        if (with_latch) begin
            m_q = d;
            m_captured = 1'b1;
        end
        exp_err = !m_captured || (d != m_q) || (inj && INJ_BUILD);
        if (!m_captured) m_proto = 1'b1;
        if (exp_err) begin
            m_q = d;
            if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
        end
        m_captured = 1'b0;

        @(negedge clk);
        data_in = d;
        sample  = 1'b1;
        inject  = inj;
        if (with_latch) latch = 1'b1;
        repeat (3) @(posedge clk);
        #1 check({tag, ".early"}, 32'({err0, err1}), 32'(2'b00));
        @(posedge clk);
        #1;
        check({tag, ".err0"}, 32'(err0), 32'(!exp_err));
        check({tag, ".err1"}, 32'(err1), 32'(exp_err));
        check_state(tag);
        repeat (2) @(negedge clk);
        sample = 1'b0;
        latch  = 1'b0;
        repeat (3) @(posedge clk);
        #1 check({tag, ".rtz"}, 32'({err0, err1}), 32'(2'b00));
        repeat (2) @(posedge clk);
        inject = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] d;
        int kind;

        rst = 1'b1; latch = 1'b0; sample = 1'b0; inject = 1'b0; data_in = '0;
        model_reset();
        #20 rst = 1'b0;
        @(posedge clk);
        #1;
        check("reset.err", 32'({err0, err1}), 32'(2'b00));
        check_state("reset");

        do_sample("nolatch", 8'h00, 1'b0, 1'b0);
        check("nolatch.cnt1", 32'(err_cnt), 32'd1);

        do_latch(8'hA5);
        do_sample("match_a5", 8'hA5, 1'b0, 1'b0);

        do_latch(8'h3C);
        do_sample("mismatch_3d", 8'h3D, 1'b0, 1'b0);
        check("mismatch_3d.q", 32'(q_out), 32'h3D);

        do_sample("simul", 8'h77, 1'b1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            d    = DATA_W'($urandom);
            kind = $urandom_range(0, 3);
            if (kind == 0) begin
                do_sample("rnd_proto", d, 1'b0, 1'b0);
            end else if (kind == 1) begin
                do_latch(d);
                do_sample("rnd_mis", d ^ DATA_W'($urandom_range(1, 255)), 1'b0, 1'b0);
            end else begin
                do_latch(d);
                do_sample("rnd_match", d, 1'b0, 1'b0);
            end
        end

        for (int i = 0; i < 16; i++) begin
            d = DATA_W'($urandom);
            do_latch(d);
            do_sample("sat", d ^ 8'h01, 1'b0, 1'b0);
        end
        check("sat.cnt15", 32'(err_cnt), 32'd15);

        // Reset during RESP with err1 high must clear without a clock edge
        do_latch(8'h11);
        @(negedge clk);
        data_in = 8'h22;
        sample  = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("midrst.pre_err1", 32'(err1), 32'd1);
        #2;
        rst    = 1'b1;
        sample = 1'b0;
        #1;
        model_reset();
        check("midrst.err", 32'({err0, err1}), 32'(2'b00));
        check_state("midrst");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        do_latch(8'h5A);
        do_sample("after_rst", 8'h5A, 1'b0, 1'b0);

        do_latch(8'hC3);
        do_sample("inject", 8'hC3, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
